// File: rtl/fp_result_pack_buf_if.sv
// Handshake and data bus of the floating-point result packing stage.
// The master drives operands and consumer controls; the slave is the packing block.
interface fp_result_pack_buf_if #(
    parameter int W  = 32,
    parameter int EW = 8,
    parameter int SW = 23
);
    logic          in_valid_i;
    logic          in_ready_o;
    logic          sign_i;
    logic [EW-1:0] exp_i;
    logic [SW-1:0] sgf_i;
    logic          nan_i;
    logic          ovf_i;
    logic          unf_i;
    logic          inexact_i;
    logic          sat_mode_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [W-1:0]  result_o;
    logic [3:0]    flags_o;
    logic [3:0]    sticky_flags_o;
    logic          clr_flags_i;
    logic [15:0]   result_count_o;

    modport master (
        output in_valid_i, sign_i, exp_i, sgf_i, nan_i, ovf_i, unf_i,
               inexact_i, sat_mode_i, out_ready_i, clr_flags_i,
        input  in_ready_o, out_valid_o, result_o, flags_o,
               sticky_flags_o, result_count_o
    );

    modport slave (
        input  in_valid_i, sign_i, exp_i, sgf_i, nan_i, ovf_i, unf_i,
               inexact_i, sat_mode_i, out_ready_i, clr_flags_i,
        output in_ready_o, out_valid_o, result_o, flags_o,
               sticky_flags_o, result_count_o
    );
endinterface

// File: rtl/fp_result_pack_buf.sv
// Final FP add/sub result packing: special-case resolution, IEEE word packing,
// 2-entry output buffer, sticky exception flags and delivered-result counter.
module fp_result_pack_buf #(
    parameter int W  = 32,
    parameter int EW = 8,
    parameter int SW = 23
) (
    input  logic                  clk,
    input  logic                  rst,
    fp_result_pack_buf_if.slave   bus
);
    logic [1:0]   count_reg;
    logic [W-1:0] data_reg [2];
    logic [3:0]   flag_reg [2];
    logic [3:0]   sticky_reg;
    logic [15:0]  rcount_reg;

    logic         in_ready;
    logic         out_valid;
    logic         push;
    logic         pop;
    logic         wr_idx;
    logic [W-1:0] packed_word;
    logic [3:0]   packed_flags;

    // Ready depends only on the count register, never on out_ready_i.
    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = bus.in_valid_i & in_ready;
    assign pop       = out_valid & bus.out_ready_i;
    // A new entry goes to the head slot when the buffer is empty or the head leaves now.
    assign wr_idx    = !((count_reg == 2'd0) || pop);

    always_comb begin
        packed_word = {bus.sign_i, bus.exp_i, bus.sgf_i};
        if (bus.nan_i) begin
            packed_word = {1'b0, {EW{1'b1}}, 1'b1, {(SW-1){1'b0}}};
        end else if (bus.ovf_i) begin
            if (bus.sat_mode_i)
                packed_word = {bus.sign_i, {(EW-1){1'b1}}, 1'b0, {SW{1'b1}}};
            else
                packed_word = {bus.sign_i, {EW{1'b1}}, {SW{1'b0}}};
        end else if (bus.unf_i) begin
            packed_word = {bus.sign_i, {(EW+SW){1'b0}}};
        end
    end

    assign packed_flags = {bus.nan_i,
                           bus.ovf_i & ~bus.nan_i,
                           bus.unf_i & ~bus.nan_i & ~bus.ovf_i,
                           ~bus.nan_i & (bus.inexact_i | bus.ovf_i | bus.unf_i)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg   <= 2'd0;
            data_reg[0] <= '0;
            data_reg[1] <= '0;
            flag_reg[0] <= '0;
            flag_reg[1] <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
            if (pop) begin
                data_reg[0] <= data_reg[1];
                flag_reg[0] <= flag_reg[1];
            end
            // Placed after the shift so a same-cycle push into slot 0 wins.
            if (push) begin
                data_reg[wr_idx] <= packed_word;
                flag_reg[wr_idx] <= packed_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sticky_reg <= 4'd0;
            rcount_reg <= 16'd0;
        end else begin
            if (bus.clr_flags_i)
                sticky_reg <= pop ? flag_reg[0] : 4'd0;
            else if (pop)
                sticky_reg <= sticky_reg | flag_reg[0];
            if (pop)
                rcount_reg <= rcount_reg + 16'd1;
        end
    end

    assign bus.in_ready_o     = in_ready;
    assign bus.out_valid_o    = out_valid;
    assign bus.result_o       = data_reg[0];
    assign bus.flags_o        = flag_reg[0];
    assign bus.sticky_flags_o = sticky_reg;
    assign bus.result_count_o = rcount_reg;
endmodule

// File: tb/tb_fp_result_pack_buf.sv
// Bench for fp_result_pack_buf: directed special cases plus randomized traffic
// against a queue-based reference model; one double-precision instance.
module tb_fp_result_pack_buf;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    fp_result_pack_buf_if #(.W(32), .EW(8),  .SW(23)) bi ();
    fp_result_pack_buf_if #(.W(64), .EW(11), .SW(52)) bd ();

    fp_result_pack_buf #(.W(32), .EW(8), .SW(23)) dut_sp (
        .clk (clk),
        .rst (rst),
        .bus (bi)
    );

    fp_result_pack_buf #(.W(64), .EW(11), .SW(52)) dut_dp (
        .clk (clk),
        .rst (rst),
        .bus (bd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference state: queue of {flags, word}, sticky flags, delivered count.
    logic [35:0] exp_q [$];
    logic [3:0]  sticky_m;
    logic [15:0] cnt_m;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // exc = {nan, ovf, unf, inexact}
    function automatic logic [35:0] ref_pack(input logic [31:0] w, input logic [3:0] exc,
                                             input logic sat);
        logic [31:0] sgn;
        sgn = w[31] ? 32'h8000_0000 : 32'h0;
        if (exc[3]) return {4'b1000, 32'h7FC0_0000};
        if (exc[2]) return {4'b0101, sat ? (sgn | 32'h7F7F_FFFF) : (sgn | 32'h7F80_0000)};
        if (exc[1]) return {4'b0011, sgn};
        return {3'b000, exc[0], w};
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        sticky_m = 4'd0;
        cnt_m    = 16'd0;
    endfunction

    // One clock cycle on the single-precision DUT: drive, check, update model, advance.
    task automatic cyc(input logic v, input logic [31:0] w, input logic [3:0] exc,
                       input logic sat, input logic ordy, input logic clr);
        logic        exp_vld;
        logic        exp_rdy;
        logic [35:0] head;
        bi.in_valid_i  = v;
        bi.sign_i      = w[31];
        bi.exp_i       = w[30:23];
        bi.sgf_i       = w[22:0];
        bi.nan_i       = exc[3];
        bi.ovf_i       = exc[2];
        bi.unf_i       = exc[1];
        bi.inexact_i   = exc[0];
        bi.sat_mode_i  = sat;
        bi.out_ready_i = ordy;
        bi.clr_flags_i = clr;
        #3;
        exp_vld = (exp_q.size() != 0);
        exp_rdy = (exp_q.size() != 2);
        check("out_valid", bi.out_valid_o, exp_vld);
        check("in_ready", bi.in_ready_o, exp_rdy);
        check("sticky", bi.sticky_flags_o, sticky_m);
        check("count", bi.result_count_o, cnt_m);
        if (exp_vld) begin
            check("result", bi.result_o, exp_q[0][31:0]);
            check("flags", bi.flags_o, exp_q[0][35:32]);
        end
        if (exp_vld && ordy) begin
            head     = exp_q.pop_front();
            cnt_m    = cnt_m + 16'd1;
            sticky_m = clr ? head[35:32] : (sticky_m | head[35:32]);
        end else if (clr) begin
            sticky_m = 4'd0;
        end
        if (v && exp_rdy) exp_q.push_back(ref_pack(w, exc, sat));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] w;
        logic [3:0]  exc;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        model_reset();
        cyc_idle_init();
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", bi.out_valid_o, 1'b0);
        check("rst_ready", bi.in_ready_o, 1'b1);
        check("rst_result", bi.result_o, 32'h0);
        check("rst_flags", bi.flags_o, 4'h0);
        check("rst_sticky", bi.sticky_flags_o, 4'h0);
        check("rst_count", bi.result_count_o, 16'h0);
        rst = 1'b1;

        // Normal passthrough, one-edge latency.
        cyc(1'b1, {1'b0, 8'h80, 23'h400000}, 4'b0000, 1'b0, 1'b1, 1'b0);
        check("norm_word", bi.result_o, 32'h4040_0000);
        check("norm_flags", bi.flags_o, 4'b0000);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        check("norm_cnt", bi.result_count_o, 16'd1);

        // Overflow to infinity, then saturating overflow.
        cyc(1'b1, 32'hC123_4567, 4'b0100, 1'b0, 1'b1, 1'b0);
        check("ovf_inf", bi.result_o, 32'hFF80_0000);
        check("ovf_inf_flags", bi.flags_o, 4'b0101);
        cyc(1'b1, 32'hC123_4567, 4'b0100, 1'b1, 1'b1, 1'b0);
        check("ovf_sat", bi.result_o, 32'hFF7F_FFFF);
        check("ovf_sat_flags", bi.flags_o, 4'b0101);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        check("stk_ovf", bi.sticky_flags_o[2], 1'b1);

        // NaN beats overflow; inexact suppressed.
        cyc(1'b1, 32'hFFFF_FFFF, 4'b1101, 1'b0, 1'b0, 1'b0);
        check("nan_word", bi.result_o, 32'h7FC0_0000);
        check("nan_flags", bi.flags_o, 4'b1000);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);

        // Underflow keeps sign; clear in the same cycle as its delivery.
        cyc(1'b1, 32'hA5A5_A5A5, 4'b0010, 1'b0, 1'b0, 1'b0);
        check("unf_word", bi.result_o, 32'h8000_0000);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b1);
        check("clr_keep", bi.sticky_flags_o, 4'b0011);

        // Backpressure: A, B accepted, C held until space frees.
        cyc(1'b1, 32'h3F80_0001, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3F80_0002, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("bp_full", bi.in_ready_o, 1'b0);
        cyc(1'b1, 32'h3F80_0003, 4'b0000, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3F80_0003, 4'b0000, 1'b0, 1'b1, 1'b0);
        check("bp_reopen", bi.in_ready_o, 1'b1);
        cyc(1'b1, 32'h3F80_0003, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            w   = $urandom;
            exc = {($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                   ($urandom_range(0, 5) == 0), 1'($urandom)};
            cyc(($urandom_range(0, 3) != 0), w, exc, 1'($urandom),
                ($urandom_range(0, 2) != 0), ($urandom_range(0, 9) == 0));
        end

        // Reset mid-operation with the buffer full.
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 32'h4000_0000, 4'b0001, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h4100_0000, 4'b0000, 1'b0, 1'b0, 1'b0);
        check("pre_rst_full", bi.in_ready_o, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", bi.out_valid_o, 1'b0);
        check("arst_count", bi.result_count_o, 16'h0);
        check("arst_ready", bi.in_ready_o, 1'b1);
        check("arst_result", bi.result_o, 32'h0);
        bi.in_valid_i = 1'b1;
        @(posedge clk);
        #2;
        check("rst_ignore", bi.out_valid_o, 1'b0);
        bi.in_valid_i = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        cyc(1'b1, 32'h4040_0000, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 4'b0000, 1'b0, 1'b1, 1'b0);

        // Double precision overflow to +infinity.
        bd.in_valid_i  = 1'b1;
        bd.sign_i      = 1'b0;
        bd.exp_i       = 11'h3FF;
        bd.sgf_i       = 52'h1;
        bd.ovf_i       = 1'b1;
        bd.sat_mode_i  = 1'b0;
        bd.out_ready_i = 1'b0;
        @(posedge clk);
        #1;
        bd.in_valid_i  = 1'b0;
        bd.ovf_i       = 1'b0;
        check("dp_valid", bd.out_valid_o, 1'b1);
        check("dp_inf", bd.result_o, 64'h7FF0_0000_0000_0000);
        check("dp_flags", bd.flags_o, 4'b0101);
        bd.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("dp_count", bd.result_count_o, 16'd1);
        check("dp_sticky", bd.sticky_flags_o, 4'b0101);
        check("dp_empty", bd.out_valid_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    task automatic cyc_idle_init();
        bi.in_valid_i  = 1'b0;
        bi.sign_i      = 1'b0;
        bi.exp_i       = '0;
        bi.sgf_i       = '0;
        bi.nan_i       = 1'b0;
        bi.ovf_i       = 1'b0;
        bi.unf_i       = 1'b0;
        bi.inexact_i   = 1'b0;
        bi.sat_mode_i  = 1'b0;
        bi.out_ready_i = 1'b0;
        bi.clr_flags_i = 1'b0;
        bd.in_valid_i  = 1'b0;
        bd.sign_i      = 1'b0;
        bd.exp_i       = '0;
        bd.sgf_i       = '0;
        bd.nan_i       = 1'b0;
        bd.ovf_i       = 1'b0;
        bd.unf_i       = 1'b0;
        bd.inexact_i   = 1'b0;
        bd.sat_mode_i  = 1'b0;
        bd.out_ready_i = 1'b0;
        bd.clr_flags_i = 1'b0;
    endtask
endmodule
